// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO that feeds the Uart transmitter.
// Producers write whenever FULL is low. The Uart drains bytes through the OE/RDY handshake.
module uart_tx_fifo #(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [7:0]        IN,
    input  logic              WE,
    output logic              FULL,
    output logic [7:0]        OUT,
    output logic              OE,
    input  logic              RDY,
    output logic [ADDR_W:0]   COUNT,
    output logic              OVF,
    input  logic              CLR_OVF
);

    // Handshake: a byte moves to the Uart on every CLK edge where OE=1 and RDY=1.
    // OUT always shows the head byte and is meaningful only while OE=1.
    // A write is accepted on every edge where WE=1 and FULL=0. A write while FULL is dropped and flagged in OVF.

    localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] COUNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_next;
    logic              push;
    logic              pop;

    // Both qualifiers use registered flags, so a write into a full FIFO is rejected even when a pop happens in the same cycle.
    assign push = WE & ~FULL;
    assign pop  = OE & RDY;
    assign OUT  = mem[rd_ptr];

    always_comb begin
        count_next = COUNT;
        case ({push, pop})
            2'b10:   count_next = COUNT + COUNT_ONE;
            2'b01:   count_next = COUNT - COUNT_ONE;
            default: count_next = COUNT;
        endcase
    end

    // Storage is deliberately left unreset. Only the pointers define what is valid.
    always_ff @(posedge CLK) begin
        if (RST_N && push) begin
            mem[wr_ptr] <= IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            COUNT  <= '0;
            OE     <= 1'b0;
            FULL   <= 1'b0;
            OVF    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            COUNT <= count_next;
            OE    <= (count_next != '0);
            FULL  <= (count_next == COUNT_FULL);
            // When set and clear happen together, set wins.
            if (WE && FULL) begin
                OVF <= 1'b1;
            end else if (CLR_OVF) begin
                OVF <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: fixed vector table, directed corner sequences and random traffic.
// The reference model is a byte queue plus an overflow bit.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          CLK = 1'b0;
    logic          RST_N = 1'b1;
    logic [7:0]    IN = '0;
    logic          WE = 1'b0;
    logic          FULL;
    logic [7:0]    OUT;
    logic          OE;
    logic          RDY = 1'b0;
    logic [AW:0]   COUNT;
    logic          OVF;
    logic          CLR_OVF = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_q[$];
    bit         m_ovf = 1'b0;
    logic [7:0] rx_q[$];

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N), .IN(IN), .WE(WE), .FULL(FULL), .OUT(OUT),
        .OE(OE), .RDY(RDY), .COUNT(COUNT), .OVF(OVF), .CLR_OVF(CLR_OVF)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Drive one cycle. The model is advanced from its own pre-edge state, and each popped byte is checked against the model head.
    task automatic cycle(input bit rst_n_v, input bit we_v, input logic [7:0] din,
                         input bit rdy_v, input bit clr_v);
        bit m_full, m_oe;
        RST_N = rst_n_v; WE = we_v; IN = din; RDY = rdy_v; CLR_OVF = clr_v;
        m_full = (m_q.size() == DEPTH);
        m_oe   = (m_q.size() != 0);
        if (!rst_n_v) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (m_oe && rdy_v) begin
                check("pop_data", int'(OUT), int'(m_q[0]));
                rx_q.push_back(OUT);
                void'(m_q.pop_front());
            end
            if (we_v && !m_full) m_q.push_back(din);
            if (we_v && m_full) m_ovf = 1'b1;
            else if (clr_v)     m_ovf = 1'b0;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".count"}, int'(COUNT), m_q.size());
        check({tag, ".oe"},    int'(OE),    int'(m_q.size() != 0));
        check({tag, ".full"},  int'(FULL),  int'(m_q.size() == DEPTH));
        check({tag, ".ovf"},   int'(OVF),   int'(m_ovf));
        if (m_q.size() != 0) check({tag, ".out"}, int'(OUT), int'(m_q[0]));
    endtask

    typedef struct {
        bit         rst_n;
        bit         we;
        logic [7:0] din;
        bit         rdy;
        bit         clr;
        int         exp_count;
        bit         exp_oe;
        bit         exp_full;
        bit         exp_ovf;
        logic [7:0] exp_out;
    } vec_t;

    vec_t vecs[11];

    initial begin
        string msg;
        int    sent;
        int    max_count;

        // {rst_n, we, din, rdy, clr, count, oe, full, ovf, out}
        vecs[0]  = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00};
        vecs[1]  = '{1, 0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00};
        vecs[2]  = '{1, 1, 8'h48, 0, 0, 1, 1, 0, 0, 8'h48};
        vecs[3]  = '{1, 0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00};
        vecs[4]  = '{1, 1, 8'h41, 1, 0, 1, 1, 0, 0, 8'h41};
        vecs[5]  = '{1, 1, 8'h42, 1, 0, 1, 1, 0, 0, 8'h42};
        vecs[6]  = '{1, 0, 8'h00, 0, 1, 1, 1, 0, 0, 8'h42};
        vecs[7]  = '{1, 0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00};
        vecs[8]  = '{1, 1, 8'h55, 0, 0, 1, 1, 0, 0, 8'h55};
        vecs[9]  = '{0, 1, 8'h77, 1, 0, 0, 0, 0, 0, 8'h00};
        vecs[10] = '{1, 1, 8'h66, 0, 0, 1, 1, 0, 0, 8'h66};

        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].rst_n, vecs[i].we, vecs[i].din, vecs[i].rdy, vecs[i].clr);
            check($sformatf("vec%0d.count", i), int'(COUNT), vecs[i].exp_count);
            check($sformatf("vec%0d.oe", i),    int'(OE),    int'(vecs[i].exp_oe));
            check($sformatf("vec%0d.full", i),  int'(FULL),  int'(vecs[i].exp_full));
            check($sformatf("vec%0d.ovf", i),   int'(OVF),   int'(vecs[i].exp_ovf));
            if (vecs[i].exp_oe) check($sformatf("vec%0d.out", i), int'(OUT), int'(vecs[i].exp_out));
        end

        // Reset, then idle with RDY high: nothing may pop out of an empty FIFO.
        cycle(0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 0, 8'h00, 1, 0);
            check_model("idle");
        end

        // Fill the FIFO, overflow it once, then drain it. 0xAA must never come out.
        for (int i = 0; i < DEPTH; i++) cycle(1, 1, 8'(i), 0, 0);
        check("fill.full", int'(FULL), 1);
        check("fill.count", int'(COUNT), DEPTH);
        cycle(1, 1, 8'hAA, 0, 0);
        check("ovf.set", int'(OVF), 1);
        check("ovf.count", int'(COUNT), DEPTH);
        rx_q.delete();
        for (int i = 0; i < DEPTH + 2; i++) cycle(1, 0, 8'h00, 1, 0);
        check("drain.n", rx_q.size(), DEPTH);
        for (int i = 0; i < rx_q.size(); i++) check("drain.seq", int'(rx_q[i]), i);
        check_model("drain");

        // A write while full is rejected even with a pop in the same cycle. Set beats clear.
        cycle(1, 0, 8'h00, 0, 1);
        for (int i = 0; i < DEPTH; i++) cycle(1, 1, 8'(8'h80 + i), 0, 0);
        cycle(1, 1, 8'hBB, 1, 0);
        check("fullpop.count", int'(COUNT), DEPTH - 1);
        check("fullpop.full", int'(FULL), 0);
        check("fullpop.ovf", int'(OVF), 1);
        cycle(1, 1, 8'h90, 0, 0);
        check("refill.full", int'(FULL), 1);
        cycle(1, 1, 8'hCC, 0, 1);
        check("setclr.ovf", int'(OVF), 1);
        cycle(1, 0, 8'h00, 0, 1);
        check("clr.ovf", int'(OVF), 0);
        check_model("clr");

        // Stream 40 bytes into a slow Uart that is ready one cycle in ten.
        cycle(0, 0, 8'h00, 0, 0);
        rx_q.delete();
        msg = "Hello, world!\n";
        sent = 0;
        max_count = 0;
        for (int cyc = 0; cyc < 2000 && rx_q.size() < 40; cyc++) begin
            bit do_we;
            do_we = (sent < 40) && (m_q.size() < DEPTH);
            cycle(1, do_we, msg[sent % msg.len()], (cyc % 10) == 9, 0);
            if (do_we) sent++;
            if (int'(COUNT) > max_count) max_count = int'(COUNT);
            check_model("stream");
        end
        check("stream.n", rx_q.size(), 40);
        for (int i = 0; i < rx_q.size(); i++) check("stream.byte", int'(rx_q[i]), int'(msg[i % msg.len()]));
        check("stream.max_le_depth", int'(max_count <= DEPTH), 1);

        // A reset in the middle of the stream discards the contents and overrides WE and RDY.
        for (int i = 0; i < 8; i++) cycle(1, 1, 8'(8'h30 + i), 0, 0);
        cycle(1, 1, 8'h01, 0, 0);
        cycle(1, 1, 8'h01, 0, 0);
        for (int i = 0; i < DEPTH; i++) cycle(1, 1, 8'h02, 0, 0);
        check("pre_rst.ovf", int'(OVF), 1);
        cycle(0, 1, 8'hEE, 1, 0);
        check("rst.count", int'(COUNT), 0);
        check("rst.oe", int'(OE), 0);
        check("rst.ovf", int'(OVF), 0);
        cycle(1, 1, 8'h55, 0, 0);
        check("post_rst.oe", int'(OE), 1);
        check("post_rst.out", int'(OUT), 8'h55);

        // Random traffic with occasional resets and overflow clears.
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 99) != 0, $urandom_range(0, 2) != 0, 8'($urandom),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
            check_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
